updown_counter_host: RTL and testbench
======================================

Name: updown_counter_host

Overview:
- Bus initiator that programs and runs the 8-bit up/down counter (PLR/ULR/LLR/CCR register set) over its ncs/nwr/nrd/a1/a0/din interface.
- On a `go` request it performs four things in order:
  - writes the four registers;
  - reads them back and compares;
  - checks the counter's `err`, then pulses `start`;
  - waits for `ec` and reports a status code.
- Sits between system control logic and the counter block, replacing hand-driven bench stimulus.

Parameters:
- START_W, 2, width of the `start` pulse in clk cycles (1..15).
- TIMEOUT, 1023, maximum cycles to wait for `ec` after `start` falls (10-bit watchdog).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- go  input  1  one-cycle request; sampled only in IDLE.
- cfg_plr  input  8  preload value.
- cfg_ulr  input  8  upper limit.
- cfg_llr  input  8  lower limit.
- cfg_ccr  input  8  cycle count.
- busy  output  1  high from the cycle after `go` until `done`.
- done  output  1  one-cycle pulse at end of sequence.
- status  output  2  valid with `done`, held until next `go`: 00 ok, 01 err, 10 readback mismatch, 11 timeout.
- ncs  output  1  counter chip select, active low.
- nwr  output  1  write strobe, active low.
- nrd  output  1  read strobe, active low.
- a1  output  1  register address bit 1.
- a0  output  1  register address bit 0.
- din  inout  8  shared data bus; driven only while nwr=0 and ncs=0, else high-Z.
- start  output  1  counter start pulse.
- err  input  1  counter limit-error flag.
- ec  input  1  counter end-of-cycles flag.

Behaviour:
- Address map {a1,a0}: 00 PLR, 01 ULR, 10 LLR, 11 CCR.
- Fixed order for both write and read: ULR, LLR, PLR, CCR.
- Reset (reset=0, async) values:
  - ncs=1, nwr=1, nrd=1, start=0, busy=0, done=0, status=00;
  - a1=a0=0, din high-Z;
  - FSM in IDLE, latched config cleared.
- IDLE:
  - On go=1, latch all cfg_* inputs; later changes to cfg_* are ignored.
  - Set busy=1 next cycle and go to W_SETUP.
  - `go` outside IDLE is ignored.
- Write access, 3 cycles per register:
  - W_SETUP: ncs=0, address valid, din driven.
  - W_STROBE: nwr=0.
  - W_HOLD: nwr=1, ncs=0, din still driven.
  - Then next register's W_SETUP; after CCR go to R_SETUP.
- Read access, 3 cycles per register:
  - R_SETUP: ncs=0, address valid, din high-Z.
  - R_STROBE: nrd=0; din sampled at the rising edge ending this cycle.
  - R_HOLD: nrd=1.
  - Compare each sample with the latched value; any mismatch sets a sticky mismatch bit.
  - After the CCR read go to CHECK.
- CHECK (1 cycle, ncs=0): sample `err`.
  - err=1 -> status 01, DONE.
  - mismatch -> status 10, DONE.
  - err takes priority over mismatch.
  - Otherwise go to START.
- START: start=1 for exactly START_W cycles with ncs=0, then start=0.
  - Latched CCR==0 -> status 00, DONE; no ec wait.
  - Otherwise go to WAIT_EC.
- WAIT_EC: ncs=0, 10-bit watchdog counts from 0.
  - ec=1 -> status 00, DONE.
  - err=1 -> status 01, DONE.
  - watchdog reaches TIMEOUT -> status 11, DONE.
  - Same-cycle priority: err > ec > timeout.
- DONE (1 cycle): done=1, busy=0 in the same cycle, ncs=1, then IDLE.
- Bus rules:
  - nwr and nrd are never low simultaneously.
  - ncs returns high only in DONE/IDLE.
  - din is never driven during reads or IDLE.
- Reset asserted mid-sequence: bus goes idle immediately (ncs=1, din high-Z), no done pulse.
- Latency for a successful run: go -> first W_SETUP = 1 cycle; writes 12; reads 12; CHECK 1; start START_W; then the ec wait.

Test Plan:
1. PLR=10, ULR=20, LLR=5, CCR=2, counter model echoes registers and raises ec 40 cycles after start -> 4 writes in order 01,10,00,11 with correct din; start high exactly 2 cycles; done with status 00; busy high throughout.
2. PLR=30, ULR=20, LLR=5 (counter err=1 after writes) -> no start pulse; done with status 01 immediately after CHECK.
3. Model returns 0x13 for the ULR read (written 0x14) -> status 10, start never asserted.
4. CCR=3, model never asserts ec, TIMEOUT=50 -> done with status 11 exactly 50 cycles after start falls.
5. CCR=0 -> start pulse issued, done the cycle after the pulse ends, status 00.
6. Assert reset during the third write's W_STROBE -> ncs=nwr=1 and din high-Z in the same cycle; no done; a new `go` after release runs a full clean sequence.

Source files
------------

// File: rtl/updown_counter_host_if.sv
// Control/status bus between the counter host and the 8-bit up/down counter.
// The shared data bus is not part of this bundle; it stays a plain inout
// port on the host so that it resolves as an ordinary tristate net.
interface updown_counter_host_if;
  logic ncs;    // chip select, active low
  logic nwr;    // write strobe, active low
  logic nrd;    // read strobe, active low
  logic a1;     // register address bit 1
  logic a0;     // register address bit 0
  logic start;  // counter start pulse
  logic err;    // counter limit-error flag
  logic ec;     // counter end-of-cycles flag

  // Host side drives the strobes and address and watches the flags.
  modport master (output ncs, nwr, nrd, a1, a0, start, input err, ec);
  // Counter side.
  modport slave  (input ncs, nwr, nrd, a1, a0, start, output err, ec);
endinterface

// File: rtl/updown_counter_host.sv
// Bus initiator for the 8-bit up/down counter.
// Writes ULR, LLR, PLR, CCR; reads them back and compares; checks err; pulses
// start; then waits for ec under a watchdog. It reports a 2-bit status with a
// one-cycle done pulse.
// Status codes: 00 ok, 01 counter err, 10 readback mismatch, 11 timeout.
// Handshake: go is a one-cycle request taken only in IDLE. busy is high from
// the next cycle until done. done is a single cycle, and status is valid with
// done and held until the next accepted go.
module updown_counter_host #(
  parameter int unsigned START_W = 2,     // start pulse width, 1..15 cycles
  parameter int unsigned TIMEOUT = 1023   // ec watchdog limit, fits 10 bits
) (
  input  logic                         clk,
  input  logic                         reset,    // async, active low
  input  logic                         go,
  input  logic [7:0]                   cfg_plr,
  input  logic [7:0]                   cfg_ulr,
  input  logic [7:0]                   cfg_llr,
  input  logic [7:0]                   cfg_ccr,
  output logic                         busy,
  output logic                         done,
  output logic [1:0]                   status,
  inout  wire  [7:0]                   din,
  updown_counter_host_if.master        cnt,
  output logic [3:0]                   dbg_state_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_W_SETUP, S_W_STROBE, S_W_HOLD,
    S_R_SETUP, S_R_STROBE, S_R_HOLD,
    S_CHECK, S_START, S_WAIT_EC, S_DONE
  } state_e;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_ERR      = 2'b01;
  localparam logic [1:0] ST_MISMATCH = 2'b10;
  localparam logic [1:0] ST_TIMEOUT  = 2'b11;

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;            // position in ULR, LLR, PLR, CCR order
  logic [7:0] plr_q, ulr_q, llr_q, ccr_q;
  logic       mismatch_q, mismatch_d;
  logic [1:0] status_q, status_d;
  logic [3:0] stw_q, stw_d;            // start pulse width counter
  logic [9:0] wd_q, wd_d;              // ec watchdog
  logic       cfg_load;

  logic [1:0] reg_addr;
  logic [7:0] reg_data;
  logic       din_oe;

  // Map the access index onto the register address and its latched value.
  always_comb begin
    reg_addr = 2'b01;
    reg_data = ulr_q;
    case (idx_q)
      2'd0:    begin reg_addr = 2'b01; reg_data = ulr_q; end
      2'd1:    begin reg_addr = 2'b10; reg_data = llr_q; end
      2'd2:    begin reg_addr = 2'b00; reg_data = plr_q; end
      default: begin reg_addr = 2'b11; reg_data = ccr_q; end
    endcase
  end

  // State and sequencing registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      idx_q      <= 2'd0;
      mismatch_q <= 1'b0;
      status_q   <= ST_OK;
      stw_q      <= 4'd0;
      wd_q       <= 10'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mismatch_q <= mismatch_d;
      status_q   <= status_d;
      stw_q      <= stw_d;
      wd_q       <= wd_d;
    end
  end

  // Configuration snapshot, taken only when a request is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      plr_q <= 8'd0;
      ulr_q <= 8'd0;
      llr_q <= 8'd0;
      ccr_q <= 8'd0;
    end else if (cfg_load) begin
      plr_q <= cfg_plr;
      ulr_q <= cfg_ulr;
      llr_q <= cfg_llr;
      ccr_q <= cfg_ccr;
    end
  end

  // Next-state logic for the write/read/check/start/wait sequence.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mismatch_d = mismatch_q;
    status_d   = status_q;
    stw_d      = stw_q;
    wd_d       = wd_q;
    cfg_load   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          cfg_load   = 1'b1;
          status_d   = ST_OK;
          mismatch_d = 1'b0;
          idx_d      = 2'd0;
          state_d    = S_W_SETUP;
        end
      end
      S_W_SETUP:  state_d = S_W_STROBE;
      S_W_STROBE: state_d = S_W_HOLD;
      S_W_HOLD: begin
        // idx wraps from 3 to 0, so the reads start again at ULR.
        idx_d   = idx_q + 2'd1;
        state_d = (idx_q == 2'd3) ? S_R_SETUP : S_W_SETUP;
      end
      S_R_SETUP:  state_d = S_R_STROBE;
      S_R_STROBE: begin
        // din is sampled by the edge that ends the strobe cycle.
        if (din != reg_data) mismatch_d = 1'b1;
        state_d = S_R_HOLD;
      end
      S_R_HOLD: begin
        idx_d   = idx_q + 2'd1;
        state_d = (idx_q == 2'd3) ? S_CHECK : S_R_SETUP;
      end
      S_CHECK: begin
        if (cnt.err) begin
          status_d = ST_ERR;
          state_d  = S_DONE;
        end else if (mismatch_q) begin
          status_d = ST_MISMATCH;
          state_d  = S_DONE;
        end else begin
          stw_d   = 4'd0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (stw_q == 4'(START_W - 1)) begin
          wd_d = 10'd0;
          if (ccr_q == 8'd0) begin
            status_d = ST_OK;
            state_d  = S_DONE;
          end else begin
            state_d = S_WAIT_EC;
          end
        end else begin
          stw_d = stw_q + 4'd1;
        end
      end
      S_WAIT_EC: begin
        // Same-cycle priority: err, then ec, then watchdog expiry.
        if (cnt.err) begin
          status_d = ST_ERR;
          state_d  = S_DONE;
        end else if (cnt.ec) begin
          status_d = ST_OK;
          state_d  = S_DONE;
        end else if (wd_q == 10'(TIMEOUT - 1)) begin
          status_d = ST_TIMEOUT;
          state_d  = S_DONE;
        end else begin
          wd_d = wd_q + 10'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus and host outputs decode from the state, so reset idles them at once.
  always_comb begin
    cnt.ncs  = (state_q == S_IDLE) || (state_q == S_DONE);
    cnt.nwr  = (state_q != S_W_STROBE);
    cnt.nrd  = (state_q != S_R_STROBE);
    cnt.start = (state_q == S_START);
    din_oe   = (state_q == S_W_SETUP) || (state_q == S_W_STROBE) ||
               (state_q == S_W_HOLD);
    if (din_oe || (state_q == S_R_SETUP) || (state_q == S_R_STROBE) ||
        (state_q == S_R_HOLD)) begin
      cnt.a1 = reg_addr[1];
      cnt.a0 = reg_addr[0];
    end else begin
      cnt.a1 = 1'b0;
      cnt.a0 = 1'b0;
    end
    busy        = !cnt.ncs;
    done        = (state_q == S_DONE);
    status      = status_q;
    dbg_state_o = state_q;
  end

  assign din = din_oe ? reg_data : 8'bzzzz_zzzz;

endmodule

// File: tb/tb_updown_counter_host.sv
// Bench for updown_counter_host: directed scenarios plus randomized runs.
// The counter model stores written registers and echoes them on reads, with an
// optional corruption mask. It raises err for an out-of-range preload and
// drives ec/err at chosen offsets after start. Expected results come from
// cycle arithmetic on the documented sequence.
module tb_updown_counter_host;
  localparam int SW = 2;
  localparam int TO = 50;
  localparam int S0 = 26;   // first start cycle, counted from go (cycle 0)

  logic       clk = 1'b0;
  logic       reset;
  logic       go;
  logic [7:0] cfg_plr, cfg_ulr, cfg_llr, cfg_ccr;
  logic       busy, done;
  logic [1:0] status;
  wire  [7:0] din;
  logic [3:0] dbg_state;

  updown_counter_host_if cnt ();

  updown_counter_host #(.START_W(SW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .go(go),
    .cfg_plr(cfg_plr), .cfg_ulr(cfg_ulr), .cfg_llr(cfg_llr), .cfg_ccr(cfg_ccr),
    .busy(busy), .done(done), .status(status), .din(din),
    .cnt(cnt), .dbg_state_o(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // counter model
  logic [7:0] model_regs [4];
  logic [1:0] mask_addr;
  logic [7:0] mask_val;
  logic [7:0] rd_data;
  logic       err_live, inj_err, ec_lvl;

  always_comb begin
    rd_data = model_regs[{cnt.a1, cnt.a0}];
    if (mask_addr == {cnt.a1, cnt.a0}) rd_data = rd_data ^ mask_val;
  end
  assign din     = (!cnt.ncs && !cnt.nrd) ? rd_data : 8'bzzzz_zzzz;
  assign cnt.err = err_live | inj_err;
  assign cnt.ec  = ec_lvl;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One full go-to-done run with its own expected results.
  task automatic run_seq(input string name, input logic [7:0] plr, input logic [7:0] ulr,
                         input logic [7:0] llr, input logic [7:0] ccr,
                         input logic [1:0] m_addr, input logic [7:0] m_val,
                         input int ec_d, input int err_e);
    logic [9:0] exp_q[$];
    logic [1:0] rd_exp_q[$];
    logic [9:0] wexp;
    logic [1:0] rexp, st_seen;
    int n, w0, w1, ec_c, er_c, ev, exp_done, exp_starts, exp_st, limit;
    int first_start, start_cnt, nwr_seen, nrd_seen, done_cyc, busy_bad, viol;

    // Expected results from the sequence rules.
    exp_q.push_back({2'b01, ulr}); exp_q.push_back({2'b10, llr});
    exp_q.push_back({2'b00, plr}); exp_q.push_back({2'b11, ccr});
    rd_exp_q.push_back(2'b01); rd_exp_q.push_back(2'b10);
    rd_exp_q.push_back(2'b00); rd_exp_q.push_back(2'b11);
    exp_starts = 0;
    if ((plr > ulr) || (plr < llr)) begin
      exp_st = 1; exp_done = S0;
    end else if (m_val != 8'd0) begin
      exp_st = 2; exp_done = S0;
    end else begin
      exp_starts = SW;
      w0 = S0 + SW;
      w1 = w0 + TO - 1;
      if (ccr == 8'd0) begin
        exp_st = 0; exp_done = w0;
      end else begin
        ec_c = (ec_d < 0) ? 100000 : ((S0 + ec_d > w0) ? S0 + ec_d : w0);
        er_c = (err_e < 0) ? 100000 : ((S0 + err_e > w0) ? S0 + err_e : w0);
        ev = (ec_c < er_c) ? ec_c : er_c;
        if (ev > w1) begin
          exp_st = 3; exp_done = w1 + 1;
        end else begin
          exp_done = ev + 1;
          exp_st = (er_c <= ev) ? 1 : 0;
        end
      end
    end

    mask_addr = m_addr;
    mask_val  = m_val;
    @(negedge clk);
    cfg_plr = plr; cfg_ulr = ulr; cfg_llr = llr; cfg_ccr = ccr;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    cfg_plr = 8'($urandom); cfg_ulr = 8'($urandom);
    cfg_llr = 8'($urandom); cfg_ccr = 8'($urandom);
    n = 1; first_start = -1; start_cnt = 0; nwr_seen = 0; nrd_seen = 0;
    done_cyc = -1; busy_bad = 0; viol = 0; st_seen = 2'b00;
    limit = S0 + SW + TO + 20;
    while (done_cyc < 0 && n <= limit) begin
      if (!cnt.ncs && !cnt.nwr) begin
        nwr_seen++;
        if (exp_q.size() > 0) begin
          wexp = exp_q.pop_front();
          check({name, "_wr"}, {22'd0, cnt.a1, cnt.a0, din}, {22'd0, wexp});
        end
        model_regs[{cnt.a1, cnt.a0}] = din;
        if (nwr_seen == 4)
          err_live = (model_regs[0] > model_regs[1]) || (model_regs[0] < model_regs[2]);
      end
      if (!cnt.nrd) begin
        nrd_seen++;
        if (rd_exp_q.size() > 0) begin
          rexp = rd_exp_q.pop_front();
          check({name, "_rd_addr"}, {30'd0, cnt.a1, cnt.a0}, {30'd0, rexp});
        end
      end
      if (cnt.start) begin
        if (first_start < 0) first_start = n;
        start_cnt++;
      end
      if (!cnt.nwr && !cnt.nrd) viol++;
      if (!cnt.nwr && cnt.ncs) viol++;
      if (busy && cnt.ncs) viol++;
      if (done) begin
        done_cyc = n;
        st_seen  = status;
        if (busy) busy_bad++;
      end else if (!busy) begin
        busy_bad++;
      end
      // A request while busy must be ignored.
      go = (n == 14);
      if (first_start >= 0 && ec_d >= 0 && n >= first_start + ec_d) ec_lvl = 1'b1;
      if (first_start >= 0 && err_e >= 0 && n >= first_start + err_e) inj_err = 1'b1;
      if (done_cyc < 0) begin
        @(negedge clk);
        n++;
      end
    end
    go = 1'b0;
    check({name, "_done_seen"}, (done_cyc >= 0), 1);
    check({name, "_done_cycle"}, done_cyc, exp_done);
    check({name, "_status"}, st_seen, exp_st);
    check({name, "_writes"}, nwr_seen, 4);
    check({name, "_reads"}, nrd_seen, 4);
    check({name, "_start_len"}, start_cnt, exp_starts);
    if (exp_starts > 0) check({name, "_start_cycle"}, first_start, S0);
    check({name, "_busy"}, busy_bad, 0);
    check({name, "_bus_rules"}, viol, 0);
    ec_lvl = 1'b0; inj_err = 1'b0; err_live = 1'b0;
    @(negedge clk);
    check({name, "_status_hold"}, status, exp_st);
    check({name, "_done_1cyc"}, {done, busy, cnt.ncs}, 3'b001);
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  // Reset asserted during the third write strobe.
  task automatic reset_mid();
    int done_seen;
    done_seen = 0;
    @(negedge clk);
    cfg_plr = 8'd10; cfg_ulr = 8'd20; cfg_llr = 8'd5; cfg_ccr = 8'd2;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (7) @(negedge clk);       // now in cycle 8
    check("rstmid_pre_nwr", cnt.nwr, 0);
    reset = 1'b0;
    #1;
    check("rstmid_ncs", cnt.ncs, 1);
    check("rstmid_nwr", cnt.nwr, 1);
    check("rstmid_busy", busy, 0);
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("rstmid_no_done", done_seen, 0);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] l, u, p, c, mv;
    int sc, ed, ee;
    reset = 1'b0; go = 1'b0;
    cfg_plr = 8'd0; cfg_ulr = 8'd0; cfg_llr = 8'd0; cfg_ccr = 8'd0;
    err_live = 1'b0; inj_err = 1'b0; ec_lvl = 1'b0;
    mask_addr = 2'b00; mask_val = 8'd0;
    for (int i = 0; i < 4; i++) model_regs[i] = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_strobes", {cnt.ncs, cnt.nwr, cnt.nrd}, 3'b111);
    check("reset_ctrl", {cnt.start, busy, done}, 3'b000);
    check("reset_status", status, 0);
    check("reset_addr", {cnt.a1, cnt.a0}, 2'b00);
    $display("[TB] reset state code %0d", dbg_state);
    reset = 1'b1;
    @(negedge clk);

    run_seq("ok_basic",   8'd10, 8'd20, 8'd5, 8'd2, 2'b00, 8'h00, 40, -1);
    run_seq("cfg_err",    8'd30, 8'd20, 8'd5, 8'd2, 2'b00, 8'h00, 40, -1);
    run_seq("rb_mm",      8'd10, 8'h14, 8'd5, 8'd2, 2'b01, 8'h07, 40, -1);
    run_seq("timeout",    8'd10, 8'd20, 8'd5, 8'd3, 2'b00, 8'h00, -1, -1);
    run_seq("ccr_zero",   8'd10, 8'd20, 8'd5, 8'd0, 2'b00, 8'h00, -1, -1);
    run_seq("err_over_mm", 8'd30, 8'd20, 8'd5, 8'd2, 2'b10, 8'h01, 40, -1);
    run_seq("ec_last",    8'd10, 8'd20, 8'd5, 8'd2, 2'b00, 8'h00, SW + TO - 1, -1);
    run_seq("ec_late",    8'd10, 8'd20, 8'd5, 8'd2, 2'b00, 8'h00, SW + TO, -1);
    run_seq("err_eq_ec",  8'd10, 8'd20, 8'd5, 8'd2, 2'b00, 8'h00, 10, 10);
    run_seq("ec_early",   8'd10, 8'd20, 8'd5, 8'd2, 2'b00, 8'h00, 0, -1);
    reset_mid();
    run_seq("after_rst",  8'd10, 8'd20, 8'd5, 8'd2, 2'b00, 8'h00, 40, -1);

    for (int i = 0; i < 16; i++) begin
      sc = $urandom_range(0, 4);
      l  = 8'($urandom_range(10, 100));
      u  = 8'($urandom_range(int'(l), 200));
      p  = 8'($urandom_range(int'(l), int'(u)));
      c  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      mv = 8'd0; ed = $urandom_range(0, 60); ee = -1;
      case (sc)
        1: p = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(int'(u) + 1, 255))
                                           : 8'($urandom_range(0, int'(l) - 1));
        2: mv = 8'($urandom_range(1, 255));
        3: ed = -1;
        4: ee = $urandom_range(0, 60);
        default: ;
      endcase
      run_seq("rand", p, u, l, c, 2'($urandom_range(0, 3)), mv, ed, ee);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Overall time guard.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "global timeout");
  end
endmodule
